spike_rate_encoder: RTL and testbench



---
 rtl/spike_rate_encoder.sv | 125 ++++++++++++
 tb/tb_spike_rate_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Spike encoder: turns an intensity into a rate-coded or time-to-first-spike train over a
// 2^WIDTH-cycle window, drives a weighted synaptic current and reports spikes per window.
module spike_rate_encoder #(
    parameter int unsigned WIDTH  = 8,
    parameter logic [7:0]  WEIGHT = 8'd64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             enable,
    output logic             spike,
    output logic [7:0]       i_syn,
    output logic             busy,
    output logic [WIDTH-1:0] win_count,
    output logic             window_done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] win_count_q, win_count_d;
    logic             mode_q, mode_d;
    logic             spike_q, spike_d;
    logic [7:0]       i_syn_q, i_syn_d;

    logic [WIDTH:0]   sum;
    logic             step_spike;
    logic             last_step;

    // Rate code uses the accumulator carry; TTFS fires once at step 2^WIDTH-1-I, i.e. ~I.
    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, level_q};
        last_step = (step_q == {WIDTH{1'b1}});
        if (mode_q) begin
            step_spike = (level_q != '0) && (step_q == ~level_q);
        end else begin
            step_spike = sum[WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        win_count_d = win_count_q;
        spike_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    level_d = in_data;
                    mode_d  = mode;
                    acc_d   = '0;
                    step_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (enable) begin
                    spike_d = step_spike;
                    if (!mode_q) begin
                        acc_d = sum[WIDTH-1:0];
                    end
                    step_d = step_q + WIDTH'(1);
                    cnt_d  = cnt_q + WIDTH'(step_spike);
                    if (last_step) begin
                        win_count_d = cnt_q + WIDTH'(step_spike);
                        state_d     = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        i_syn_d = spike_d ? WEIGHT : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            level_q     <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            cnt_q       <= '0;
            win_count_q <= '0;
            spike_q     <= 1'b0;
            i_syn_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            win_count_q <= win_count_d;
            spike_q     <= spike_d;
            i_syn_q     <= i_syn_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q == StRun);
    assign window_done = (state_q == StDone);
    assign spike       = spike_q;
    assign i_syn       = i_syn_q;
    assign win_count   = win_count_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: rate/TTFS windows, pause, ignored input and reset.
module tb_spike_rate_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic       enable;
    logic       spike;
    logic [7:0] i_syn;
    logic       busy;
    logic [7:0] win_count;
    logic       window_done;

    int n_checks;
    int n_bad;

    // Per-window observations filled by run_window.
    int nsp;
    int first_k;
    int last_k;
    int errs;
    int edges;
    logic last_exp;

    spike_rate_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .enable     (enable),
        .spike      (spike),
        .i_syn      (i_syn),
        .busy       (busy),
        .win_count  (win_count),
        .window_done(window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: step k of a 256-step window spikes when floor((k+1)*I/256) steps past floor(k*I/256).
    function automatic logic exp_spike(input int i, input logic m, input int k);
        if (m) return (i != 0) && (k == 255 - i);
        return (((k + 1) * i) / 256) != ((k * i) / 256);
    endfunction

    // Accept one intensity and follow the whole window. Optionally pause before step pause_at
    // for pause_len edges, and optionally hold in_valid with other data during the window.
    task automatic run_window(input int i, input logic m, input int pause_at, input int pause_len,
                              input logic poke);
        int   k;
        int   paused;
        logic e;
        in_data  = 8'(i);
        mode     = m;
        in_valid = 1'b1;
        enable   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0; paused = 0; nsp = 0; first_k = -1; last_k = -1; errs = 0; edges = 0;
        last_exp = 1'b0;
        while (!window_done && edges < 600) begin
            enable = !(k == pause_at && paused < pause_len);
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 8'd7;
                mode     = ~m;
            end
            @(posedge clk); #1;
            edges++;
            if (in_ready !== 1'b0) errs++;
            if (!enable) begin
                paused++;
                if (spike !== 1'b0 || i_syn !== 8'd0) errs++;
                if (busy !== 1'b1) errs++;
            end else begin
                e = exp_spike(i, m, k);
                if (spike !== e) errs++;
                if (i_syn !== (e ? 8'd64 : 8'd0)) errs++;
                if (spike === 1'b1) begin
                    nsp++;
                    if (first_k < 0) first_k = k;
                    last_k = k;
                end
                if (k < 255 && busy !== 1'b1) errs++;
                last_exp = e;
                k++;
            end
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        check_eq("window_done_seen", int'(window_done), 1);
        // Last step's spike/i_syn stay visible in the DONE cycle.
        check_eq("done_spike_held", int'(spike), int'(last_exp));
        check_eq("done_busy", int'(busy), 0);
        @(posedge clk); #1;
        check_eq("post_done_pulse", int'(window_done), 0);
        check_eq("post_done_ready", int'(in_ready), 1);
        check_eq("post_done_isyn", int'(i_syn), 0);
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        mode     = 1'b0;
        enable   = 1'b1;
        #12;
        check_eq("rst_ready", int'(in_ready), 1);
        check_eq("rst_spike", int'(spike), 0);
        check_eq("rst_isyn", int'(i_syn), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_wincount", int'(win_count), 0);
        check_eq("rst_done", int'(window_done), 0);
        #8 rst_n = 1'b1;
        @(posedge clk); #1;

        // Rate I=128: odd steps spike, window_done after 256 edges following the accept edge.
        run_window(128, 1'b0, -1, 0, 1'b0);
        check_eq("r128_pattern", errs, 0);
        check_eq("r128_nsp", nsp, 128);
        check_eq("r128_first", first_k, 1);
        check_eq("r128_last", last_k, 255);
        check_eq("r128_latency", edges, 256);
        check_eq("r128_wincount", int'(win_count), 128);

        // Back-to-back window with independent count.
        run_window(1, 1'b0, -1, 0, 1'b0);
        check_eq("r1_pattern", errs, 0);
        check_eq("r1_first", first_k, 255);
        check_eq("r1_wincount", int'(win_count), 1);

        run_window(255, 1'b0, -1, 0, 1'b0);
        check_eq("r255_pattern", errs, 0);
        check_eq("r255_first", first_k, 1);
        check_eq("r255_wincount", int'(win_count), 255);

        run_window(0, 1'b0, -1, 0, 1'b0);
        check_eq("r0_nsp", nsp, 0);
        check_eq("r0_wincount", int'(win_count), 0);

        run_window(200, 1'b1, -1, 0, 1'b0);
        check_eq("t200_pattern", errs, 0);
        check_eq("t200_nsp", nsp, 1);
        check_eq("t200_first", first_k, 55);
        check_eq("t200_wincount", int'(win_count), 1);

        run_window(255, 1'b1, -1, 0, 1'b0);
        check_eq("t255_first", first_k, 0);
        check_eq("t255_wincount", int'(win_count), 1);

        // Pause 10 edges before step 40.
        run_window(128, 1'b0, 40, 10, 1'b0);
        check_eq("pause_pattern", errs, 0);
        check_eq("pause_latency", edges, 266);
        check_eq("pause_wincount", int'(win_count), 128);

        // in_valid with I=7 and flipped mode held through the window: ignored.
        run_window(100, 1'b1, -1, 0, 1'b1);
        check_eq("poke_pattern", errs, 0);
        check_eq("poke_first", first_k, 155);
        check_eq("poke_wincount", int'(win_count), 1);

        run_window(128, 1'b0, -1, 0, 1'b0);
        check_eq("pre_rst_wincount", int'(win_count), 128);

        // Asynchronous reset mid-window, just after step 101 spiked.
        in_data  = 8'd128;
        mode     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (102) @(posedge clk);
        #2;
        check_eq("mid_spike", int'(spike), 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_spike", int'(spike), 0);
        check_eq("arst_isyn", int'(i_syn), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_ready", int'(in_ready), 1);
        check_eq("arst_wincount", int'(win_count), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_window(64, 1'b0, -1, 0, 1'b0);
        check_eq("r64_pattern", errs, 0);
        check_eq("r64_first", first_k, 3);
        check_eq("r64_wincount", int'(win_count), 64);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
